ram_arbiter_2p: RTL and testbench

RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

---
 rtl/ram_arbiter_2p_if.sv | 20 ++
 rtl/ram_arbiter_2p.sv | 81 ++++++++
 tb/tb_ram_arbiter_2p.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2p_if.sv
// ram_arbiter_2p_if: requester-side bus of the two-port RAM arbiter (CPU on A, loader on B).
interface ram_arbiter_2p_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              a_req, a_we, a_gnt, a_rvalid;
    logic              b_req, b_we, b_gnt, b_rvalid;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata, rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: two-requester single-port RAM arbiter, IDLE/ACC/RSP sequencing.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise A has fixed priority.
module ram_arbiter_2p #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_2p_if.slave   bus,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;

    logic [1:0]        state;
    logic              win_b;
    logic              pick_b;
    logic [DATA_W-1:0] rdata_q;

`ifdef RAM_ARB_RR_EN
    logic prefer_b;
    always_comb pick_b = bus.b_req && (!bus.a_req || prefer_b);
`else
    always_comb pick_b = bus.b_req && !bus.a_req;
`endif

    assign busy         = state != IDLE;
    assign bus.a_rvalid = state == RSP && !win_b;
    assign bus.b_rvalid = state == RSP && win_b;
    // read data is only steered from the RAM during RSP and held afterwards
    assign bus.rdata    = state == RSP ? ram_dout : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win_b        <= 1'b0;
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            rdata_q      <= '0;
`ifdef RAM_ARB_RR_EN
            prefer_b     <= 1'b0;
`endif
        end else begin
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            case (state)
                IDLE: if (bus.a_req || bus.b_req) begin
                    state        <= ACC;
                    win_b        <= pick_b;
                    bus.a_gnt    <= !pick_b;
                    bus.b_gnt    <= pick_b;
                    ram_addr     <= pick_b ? bus.b_addr : bus.a_addr;
                    ram_din      <= pick_b ? bus.b_wdata : bus.a_wdata;
                    ram_write_en <= pick_b ? bus.b_we : bus.a_we;
                    ram_read_en  <= pick_b ? !bus.b_we : !bus.a_we;
`ifdef RAM_ARB_RR_EN
                    prefer_b     <= !pick_b;
`endif
                end
                ACC:     state <= ram_write_en ? IDLE : RSP;
                RSP: begin
                    state   <= IDLE;
                    rdata_q <= ram_dout;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: vector table plus directed corner cases and random traffic, with per-requester read scoreboards.
module tb_ram_arbiter_2p;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re, wr, busy;
    logic [6:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic [15:0] mem [128];
    logic [15:0] shadow [128];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_2p_if bus ();

    ram_arbiter_2p dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ram_read_en  (re),
        .ram_write_en (wr),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .busy         (busy)
    );

    always @(posedge clk) begin
        if (wr) mem[ram_addr] <= ram_din;
        if (re) ram_dout <= mem[ram_addr];
    end

    typedef struct {
        bit          b;
        bit          we;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic gnt(input bit b);
        return b ? bus.b_gnt : bus.a_gnt;
    endfunction

    function automatic logic rv(input bit b);
        return b ? bus.b_rvalid : bus.a_rvalid;
    endfunction

    function automatic logic req(input bit b);
        return b ? bus.b_req : bus.a_req;
    endfunction

    task automatic set_req(input bit b, input bit w, input logic [6:0] ad, input logic [15:0] d);
        if (b) begin
            bus.b_req = 1'b1; bus.b_we = w; bus.b_addr = ad; bus.b_wdata = d;
        end else begin
            bus.a_req = 1'b1; bus.a_we = w; bus.a_addr = ad; bus.a_wdata = d;
        end
    endtask

    task automatic drop(input bit b);
        if (b) bus.b_req = 1'b0;
        else bus.a_req = 1'b0;
    endtask

    task automatic push(input bit b, input logic [15:0] v);
        if (b) qb.push_back(v);
        else qa.push_back(v);
    endtask

    // Called at a falling edge with the arbiter idle.
    task automatic access(input bit b, input bit w, input logic [6:0] ad, input logic [15:0] d,
                          input logic [15:0] exp);
        set_req(b, w, ad, d);
        if (w) shadow[ad] = d;
        else push(b, exp);
        @(negedge clk);
        chk("gnt", gnt(b), 1);
        chk("ram_addr", ram_addr, ad);
        chk("ram_write_en", wr, w);
        chk("ram_read_en", re, !w);
        if (w) chk("ram_din", ram_din, d);
        drop(b);
        @(negedge clk);
        if (!w) begin
            chk("rvalid", rv(b), 1);
            @(negedge clk);
        end
        chk("busy_after", busy, 0);
    endtask

    task automatic service(input bit b, input bit allow);
        logic [6:0]  ad;
        logic [15:0] d;
        bit          w;
        if (req(b)) begin
            if (gnt(b)) drop(b);
        end else if (allow && $urandom_range(0, 2) == 0) begin
            w  = 1'($urandom_range(0, 1));
            ad = {b, 6'($urandom_range(0, 63))};
            d  = 16'($urandom);
            set_req(b, w, ad, d);
            if (w) shadow[ad] = d;
            else push(b, shadow[ad]);
        end
    endtask

    always @(negedge clk) begin
        chk("excl_enables", re & wr, 0);
        chk("one_gnt", bus.a_gnt & bus.b_gnt, 0);
        chk("one_rvalid", bus.a_rvalid & bus.b_rvalid, 0);
        if (bus.a_rvalid) begin
            if (qa.size() == 0) chk("a_rvalid_unexpected", bus.a_rvalid, 0);
            else chk("a_rdata", bus.rdata, qa.pop_front());
        end
        if (bus.b_rvalid) begin
            if (qb.size() == 0) chk("b_rvalid_unexpected", bus.b_rvalid, 0);
            else chk("b_rdata", bus.rdata, qb.pop_front());
        end
    end

    initial begin
        logic [2:0] order;
`ifdef RAM_ARB_RR_EN
        order = 3'b010;
`else
        order = 3'b000;
`endif
        vecs[0]  = '{0, 1, 7'h05, 16'hBEEF, 16'h0000};
        vecs[1]  = '{0, 0, 7'h05, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1, 1, 7'h7F, 16'h1234, 16'h0000};
        vecs[3]  = '{1, 1, 7'h00, 16'h5678, 16'h0000};
        vecs[4]  = '{1, 0, 7'h7F, 16'h0000, 16'h1234};
        vecs[5]  = '{1, 0, 7'h00, 16'h0000, 16'h5678};
        vecs[6]  = '{0, 1, 7'h40, 16'hA5A5, 16'h0000};
        vecs[7]  = '{1, 0, 7'h40, 16'h0000, 16'hA5A5};
        vecs[8]  = '{0, 0, 7'h00, 16'h0000, 16'h5678};
        vecs[9]  = '{1, 1, 7'h05, 16'h0F0F, 16'h0000};
        vecs[10] = '{0, 0, 7'h05, 16'h0000, 16'h0F0F};
        for (int i = 0; i < 128; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        ram_dout = '0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {busy, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, re, wr}, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_ram_din", ram_din, 0);
        chk("reset_rdata", bus.rdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            access(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        @(negedge clk);
        chk("rdata_hold", bus.rdata, 16'h0F0F);

        // B raises and withdraws its request while A's read is in RSP
        set_req(0, 0, 7'h05, 16'h0);
        qa.push_back(16'h0F0F);
        @(negedge clk);
        chk("wd_a_gnt", bus.a_gnt, 1);
        drop(0);
        @(negedge clk);
        set_req(1, 1, 7'h22, 16'hDEAD);
        #2 drop(1);
        repeat (3) begin
            @(negedge clk);
            chk("wd_no_b_gnt", bus.b_gnt, 0);
            chk("wd_no_ram", re | wr, 0);
        end

        // reset during the ACC cycle of a read
        set_req(0, 0, 7'h10, 16'h0);
        @(negedge clk);
        chk("rst_acc_gnt", bus.a_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_enables", {re, wr}, 0);
        chk("rst_gnt", bus.a_gnt, 0);
        drop(0);
        repeat (2) @(negedge clk);
        chk("rst_no_rvalid", bus.a_rvalid, 0);

        // simultaneous reads, first one sampled on the first edge after reset release
        for (int r = 0; r < 3; r++) begin
            set_req(0, 0, 7'h05, 16'h0);
            set_req(1, 0, 7'h7F, 16'h0);
            if (r == 0) rst_n = 1'b1;
            push(order[r], order[r] ? shadow[7'h7F] : shadow[7'h05]);
            @(negedge clk);
            chk("tie_winner", {bus.a_gnt, bus.b_gnt}, order[r] ? 2'b01 : 2'b10);
            drop(0);
            drop(1);
            repeat (2) @(negedge clk);
            chk("tie_idle", busy, 0);
        end

        // random traffic; A owns the low half, B the high half so each side's data is self-consistent
        for (int c = 0; c < 1000; c++) begin
            service(0, 1);
            service(1, 1);
            @(negedge clk);
        end
        for (int c = 0; c < 200 && (bus.a_req || bus.b_req); c++) begin
            service(0, 0);
            service(1, 0);
            @(negedge clk);
        end
        chk("rand_drained_req", {bus.a_req, bus.b_req}, 0);
        repeat (4) @(negedge clk);
        chk("rand_busy", busy, 0);
        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
